// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared state encoding and default timeout for the data-memory bridge
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/dmem_timer.sv
// dmem_timer: saturating wait-cycle counter with a timeout pulse on its last allowed cycle
module dmem_timer
    import dmem_bridge_pkg::*;
#(
    parameter int MAX = DEF_TIMEOUT,
    localparam int W  = $clog2(MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tmo_o
);

    logic [W-1:0] cnt_q;

    // count enabled cycles from zero, holding at MAX rather than wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && cnt_q != W'(MAX)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // the cycle that would bring the count to MAX is the last one allowed
    assign tmo_o = en_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage load/store to valid/ready memory bus bridge with response timeout
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cpu_load_i,
    input  logic            cpu_store_i,
    input  logic [XLEN-1:0] cpu_addr_i,
    input  logic [XLEN-1:0] cpu_wdata_i,
    output logic [XLEN-1:0] cpu_rdata_o,
    output logic            stall_o,
    output logic            bus_req_valid_o,
    input  logic            bus_req_ready_i,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_resp_valid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            bus_error_o
);

    state_e          state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] hold_q;
    logic            we_q;
    logic            err_q;
    logic            tmo;

    dmem_timer #(.MAX(TIMEOUT)) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q != ST_WAIT),
        .en_i   (state_q == ST_WAIT),
        .tmo_o  (tmo)
    );

    // access sequencer: latch request, present it until accepted, await response or timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (cpu_load_i || cpu_store_i) begin
                    addr_q  <= cpu_addr_i;
                    wdata_q <= cpu_wdata_i;
                    we_q    <= cpu_store_i;
                    state_q <= ST_REQ;
                end
                ST_REQ: if (bus_req_ready_i) begin
                    if (bus_resp_valid_i) hold_q <= bus_rdata_i;
                    state_q <= bus_resp_valid_i ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: if (bus_resp_valid_i) begin
                    hold_q  <= bus_rdata_i;
                    state_q <= ST_DONE;
                end else if (tmo) begin
                    hold_q  <= '0;
                    err_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // reset gating keeps stall low while the CPU may still be presenting a request
    assign stall_o         = rst_ni && (state_q == ST_REQ || state_q == ST_WAIT ||
                                        (state_q == ST_IDLE && (cpu_load_i || cpu_store_i)));
    assign bus_req_valid_o = state_q == ST_REQ;
    assign bus_we_o        = we_q;
    assign bus_addr_o      = addr_q & ~XLEN'(3);
    assign bus_wdata_o     = wdata_q;
    assign cpu_rdata_o     = hold_q;
    assign bus_error_o     = err_q;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before an access is aborted.
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-005 cpu_load  input  1  MEM-stage load request.
REQ-006 cpu_store  input  1  MEM-stage store request.
REQ-007 cpu_addr  input  XLEN  byte address from MEM stage.
REQ-008 cpu_wdata  input  XLEN  store word, already byte-merged by the store unit.
REQ-009 cpu_rdata  output  XLEN  load word returned to MEM stage.
REQ-010 stall  output  1  pipeline hold; 1 while an access is not yet complete.
REQ-011 bus_req_valid  output  1  request valid toward memory.
REQ-012 bus_req_ready  input  1  memory accepts request.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  XLEN  word-aligned address.
REQ-015 bus_wdata  output  XLEN  write data.
REQ-016 bus_resp_valid  input  1  response/ack from memory, one cycle per request.
REQ-017 bus_rdata  input  XLEN  read data, valid with bus_resp_valid.
REQ-018 bus_error  output  1  sticky timeout flag.

Function
REQ-019 States IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-020 IDLE: if cpu_load|cpu_store, latch cpu_addr, cpu_wdata, we=cpu_store, go REQ; stall=1 combinationally this cycle.
REQ-021 cpu_load and cpu_store both 1: treated as store (we=1).
REQ-022 REQ: bus_req_valid=1, bus_we/bus_addr/bus_wdata from latches, held stable until bus_req_ready=1.
REQ-023 REQ with bus_req_ready=1 and bus_resp_valid=0: go WAIT; with both 1 same cycle: capture bus_rdata, go DONE.
REQ-024 WAIT: bus_req_valid=0; bus_resp_valid=1 captures bus_rdata into hold register, go DONE.
REQ-025 WAIT cycle counter starts at 0 on entry, increments each WAIT cycle; reaching TIMEOUT without response sets bus_error=1, loads hold register with 0, goes DONE.
REQ-026 Counter width ceil(log2(TIMEOUT+1)); no wrap, saturates at TIMEOUT.
REQ-027 DONE: stall=0, cpu_rdata=hold register for exactly one cycle, then IDLE unconditionally.
REQ-028 cpu_rdata=hold register in all states (stale value outside DONE is don't-care for the CPU).
REQ-029 stall=1 in REQ and WAIT, 0 in DONE, in IDLE equals cpu_load|cpu_store.
REQ-030 CPU holds request inputs stable while stall=1; bridge ignores changes after latching.
REQ-031 bus_resp_valid in IDLE, REQ-without-ready, or DONE: ignored, no state change.
REQ-032 bus_addr = {latched_addr[XLEN-1:2], 2'b00}.
REQ-033 Stores wait for bus_resp_valid like loads; store hold value is bus_rdata (unused).
REQ-034 Minimum access latency: 2 stall cycles (IDLE->REQ->DONE with same-cycle ready+resp).

Reset
REQ-035 On reset=0: state IDLE, counter 0, hold register 0, latches 0, bus_error 0.
REQ-036 Outputs during reset: stall=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_rdata=0.
REQ-037 Reset mid-transaction abandons it; any later stray response ignored per REQ-031.
REQ-038 bus_error cleared only by reset.

Structure
REQ-039 State encoding enum and default TIMEOUT constant in the shared defines package.
REQ-040 One sub-module dmem_timer: clear, enable, saturating count, timeout pulse.

Verification
REQ-041 Load 0x0000_1006, ready and resp same cycle as REQ, rdata 0xDEAD_BEEF -> bus_addr 0x0000_1004, bus_we 0, stall 2 cycles, cpu_rdata 0xDEAD_BEEF in DONE.
REQ-042 Store 0x0000_2000 data 0x1234_5678, ready after 3 cycles, resp 2 cycles later -> bus_wdata held stable, bus_we 1, stall deasserts only in DONE.
REQ-043 Load with no response, TIMEOUT=4 -> DONE after 4 WAIT cycles, cpu_rdata 0, bus_error 1 and stays 1 across further good accesses.
REQ-044 cpu_load and cpu_store both 1 -> bus_we 1.
REQ-045 Reset asserted in WAIT, stray bus_resp_valid after release -> state IDLE, stall 0, no capture.
REQ-046 Back-to-back loads to different addresses -> second REQ begins cycle after DONE, each rdata correct.
